// File: rtl/uart_transmit_if.sv
// Byte handshake and serial-line status bundle for uart_transmit.
interface uart_transmit_if;
    logic       i_Tx_Valid;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Serial;
    logic       o_Tx_Busy;
    logic       o_Tx_Done;

    modport master (
        output i_Tx_Valid, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Serial, o_Tx_Busy, o_Tx_Done
    );

    modport slave (
        input  i_Tx_Valid, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Serial, o_Tx_Busy, o_Tx_Done
    );
endinterface

// File: rtl/uart_transmit.sv
// FIFO-fed UART transmitter, 8N1 by default; defining UART_TX_PARITY_EN adds an
// even-parity bit (8E1). Frames are sent back to back while the FIFO holds data.
module uart_transmit #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           i_CLK,
    input  logic           i_RST_N,
    uart_transmit_if.slave tx
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_nx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            empty, full, push, pop;
    logic [7:0]      head, shift;
    logic [2:0]      bit_idx;
    logic [CW-1:0]   clk_cnt;
    logic            cnt_last;
    logic            line, line_d, done, done_d;
`ifdef UART_TX_PARITY_EN
    logic            par;
`endif

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    // No full-bypass: a pop in the same cycle does not make room for a push.
    assign push     = tx.i_Tx_Valid && !full;
    assign head     = mem[rd_ptr[PW-2:0]];
    assign cnt_last = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_CLK)
        if (push) mem[wr_ptr[PW-2:0]] <= tx.i_Tx_Byte;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (!empty) state_nx = START;
            START:  if (cnt_last) state_nx = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (cnt_last && bit_idx == 3'd7) state_nx = PARITY;
            PARITY: if (cnt_last) state_nx = STOP;
`else
            DATA:   if (cnt_last && bit_idx == 3'd7) state_nx = STOP;
`endif
            STOP:   if (cnt_last) state_nx = empty ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        line_d = 1'b1;
        done_d = 1'b0;
        case (state)
            IDLE:   pop = !empty;
            START:  line_d = 1'b0;
            DATA:   line_d = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: line_d = par;
`endif
            STOP: begin
                done_d = cnt_last;
                pop    = cnt_last && !empty;
            end
            default: line_d = 1'b1;
        endcase
    end

    // Line and done are registered from the state, so both trail it by one clock.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            line    <= 1'b1;
            done    <= 1'b0;
            shift   <= '0;
            bit_idx <= '0;
            clk_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            line <= line_d;
            done <= done_d;
            if (pop) begin
                shift   <= head;
                bit_idx <= '0;
                clk_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^head;
`endif
            end else if (state != IDLE) begin
                if (cnt_last) begin
                    clk_cnt <= '0;
                    if (state == DATA) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt <= clk_cnt + CW'(1);
                end
            end
        end
    end

    assign tx.o_Tx_Ready  = !full;
    assign tx.o_Tx_Serial = line;
    assign tx.o_Tx_Done   = done;
    assign tx.o_Tx_Busy   = (state != IDLE) || !empty;
endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench: one transmitter at 217 clocks/bit, one at 4 clocks/bit for loopback.
`timescale 1ns/1ps
module tb_uart_transmit;
`ifdef UART_TX_PARITY_EN
    localparam int FR = 11;
`else
    localparam int FR = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] byte_in = '0;
    logic       sel = 1'b0;
    int         cpb = 217;
    int         cyc = 0;
    int         n_chk = 0, n_err = 0;
    int         done_cnt = 0, done_cyc = 0;
    bit         saw_full = 0;
    logic [7:0] lb [256];

    uart_transmit_if ifa();
    uart_transmit_if ifb();

    assign ifa.i_Tx_Valid = valid && !sel;
    assign ifb.i_Tx_Valid = valid && sel;
    assign ifa.i_Tx_Byte  = byte_in;
    assign ifb.i_Tx_Byte  = byte_in;

    wire line    = sel ? ifb.o_Tx_Serial : ifa.o_Tx_Serial;
    wire ready_m = sel ? ifb.o_Tx_Ready  : ifa.o_Tx_Ready;

    uart_transmit #(.CLKS_PER_BIT(217), .FIFO_DEPTH(4)) dut_a (.i_CLK(clk), .i_RST_N(rst_n), .tx(ifa));
    uart_transmit #(.CLKS_PER_BIT(4),   .FIFO_DEPTH(4)) dut_b (.i_CLK(clk), .i_RST_N(rst_n), .tx(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ifa.o_Tx_Done) begin done_cnt++; done_cyc = cyc; end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves valid high so consecutive pushes are back to back.
    task automatic push(input logic [7:0] b, output int pc);
        int n = 0;
        valid = 1'b1; byte_in = b; pc = -1;
        while (!ready_m && n < 60*cpb) begin saw_full = 1; @(negedge clk); n++; end
        if (!ready_m) begin chk("push_timeout", 0, 1); return; end
        @(negedge clk);
        pc = cyc;
    endtask

    task automatic wait_low(output int lc);
        int n = 0;
        lc = -1;
        while (line !== 1'b0 && n < 40*cpb) begin @(negedge clk); n++; end
        if (line !== 1'b0) begin chk("low_timeout", 0, 1); return; end
        lc = cyc;
    endtask

    task automatic rx(output logic [7:0] d, output int lc);
        d = '0;
        wait_low(lc);
        if (lc < 0) return;
        repeat (cpb/2) @(negedge clk);
        chk("start_bit", line, 0);
        for (int i = 0; i < 8; i++) begin repeat (cpb) @(negedge clk); d[i] = line; end
`ifdef UART_TX_PARITY_EN
        repeat (cpb) @(negedge clk);
        chk("parity_bit", line, ^d);
`endif
        repeat (cpb) @(negedge clk);
        chk("stop_bit", line, 1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 4*cpb) begin @(negedge clk); n++; end
        chk("done_seen", done_cnt >= target, 1);
    endtask

    initial begin
        int pc, lc, l2, d0;
        logic [7:0] d, d2;

        repeat (3) @(negedge clk);
        chk("rst_line",  ifa.o_Tx_Serial, 1);
        chk("rst_ready", ifa.o_Tx_Ready, 1);
        chk("rst_busy",  ifa.o_Tx_Busy, 0);
        chk("rst_done",  ifa.o_Tx_Done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte: latency, contents, done position, busy release
        d0 = done_cnt;
        push(8'h55, pc); valid = 1'b0;
        rx(d, lc);
        chk("latency", lc - pc, 2);
        chk("byte_55", d, 8'h55);
        chk("busy_mid", ifa.o_Tx_Busy, 1);
        wait_done(d0 + 1);
        chk("done_pos", done_cyc - lc, FR*cpb - 1);
        @(negedge clk);
        chk("busy_after", ifa.o_Tx_Busy, 0);
        chk("done_once", done_cnt - d0, 1);

        // back to back
        d0 = done_cnt;
        push(8'hA3, pc); push(8'h0F, pc); valid = 1'b0;
        rx(d, lc); rx(d2, l2);
        chk("b2b_first", d, 8'hA3);
        chk("b2b_second", d2, 8'h0F);
        chk("b2b_gap", l2 - lc, FR*cpb);
        wait_done(d0 + 2);
        repeat (3*cpb) @(negedge clk);
        chk("b2b_done2", done_cnt - d0, 2);

        // full FIFO with held valid
        saw_full = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) push(8'(i), pc);
                valid = 1'b0;
            end
            begin
                for (int i = 1; i <= 6; i++) begin
                    logic [7:0] r; int l;
                    rx(r, l);
                    chk("full_order", r, 32'(i));
                end
            end
        join
        chk("full_seen", saw_full, 1);
        repeat (2*cpb) @(negedge clk);

        // reset during data bit 3
        push(8'h00, pc); valid = 1'b0;
        wait_low(lc);
        repeat (4*cpb + cpb/2) @(negedge clk);
        chk("bit3_low", line, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_line",  ifa.o_Tx_Serial, 1);
        chk("rst_mid_ready", ifa.o_Tx_Ready, 1);
        chk("rst_mid_busy",  ifa.o_Tx_Busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", ifa.o_Tx_Busy, 0);
        d0 = done_cnt;
        push(8'hC4, pc); valid = 1'b0;
        rx(d, lc);
        chk("byte_c4", d, 8'hC4);
        wait_done(d0 + 1);
        repeat (2*cpb) @(negedge clk);
        chk("c4_done_once", done_cnt - d0, 1);

`ifdef UART_TX_PARITY_EN
        push(8'h07, pc); push(8'h03, pc); valid = 1'b0;
        rx(d, lc); rx(d2, l2);
        chk("par_07", d, 8'h07);
        chk("par_03", d2, 8'h03);
        chk("par_len", l2 - lc, 11*cpb);
        repeat (2*cpb) @(negedge clk);
`endif

        // loopback at 4 clocks per bit
        sel = 1'b1; cpb = 4;
        for (int i = 0; i < 256; i++) lb[i] = 8'($urandom);
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 256; i++) push(lb[i], pc);
                valid = 1'b0;
            end
            begin
                for (int i = 0; i < 256; i++) begin
                    logic [7:0] r; int l;
                    rx(r, l);
                    chk("loopback", r, lb[i]);
                end
            end
        join
        repeat (4*cpb) @(negedge clk);
        chk("lb_idle", ifb.o_Tx_Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
